// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled step strobe driving up/down/Gray/bounce patterns.
// Optional PWM brightness control is compiled in with `define LED_SEQ_PWM_EN.
module led_sequencer #(
   parameter int unsigned WAIT_TIME  = 13500000,
   parameter int unsigned WIDTH      = 6,
   parameter int unsigned ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             pause,
   input  logic             step,
`ifdef LED_SEQ_PWM_EN
   input  logic [3:0]       brightness,
`endif
   output logic [WIDTH-1:0] led,
   output logic             tick
);

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_GRAY   = 2'b10,
      MODE_BOUNCE = 2'b11
   } mode_e;

   localparam logic [31:0]      WAIT_C   = 32'(WAIT_TIME);
   localparam logic [WIDTH-1:0] IDX_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] IDX_LAST = WIDTH'(WIDTH - 1);
   localparam logic [WIDTH-1:0] IDX_PEN  = WIDTH'(WIDTH - 2);

   logic [31:0]      presc_q, presc_d;
   logic             strobe;
   mode_e            mode_q, mode_d, mode_in;
   logic [WIDTH-1:0] idx_q, idx_d;
   logic             dir_q, dir_d;
   logic             tick_q;
   logic [WIDTH-1:0] pattern;
   logic [WIDTH-1:0] lit;

   assign mode_in = mode_e'(mode);

   // While paused the prescaler is frozen and only the step pulse can advance.
   always_comb begin
      presc_d = presc_q;
      strobe  = 1'b0;
      if (pause) begin
         strobe = step;
      end else if (presc_q >= WAIT_C) begin
         presc_d = 32'd1;
         strobe  = 1'b1;
      end else begin
         presc_d = presc_q + 32'd1;
      end
   end

   always_comb begin
      idx_d  = idx_q;
      dir_d  = dir_q;
      mode_d = mode_q;
      if (strobe) begin
         if (mode_in != mode_q) begin
            // A mode change consumes the strobe to load the start state.
            mode_d = mode_in;
            dir_d  = 1'b0;
            idx_d  = (mode_in == MODE_DOWN) ? '1 : '0;
         end else begin
            case (mode_q)
               MODE_UP, MODE_GRAY: idx_d = idx_q + IDX_ONE;
               MODE_DOWN:          idx_d = idx_q - IDX_ONE;
               MODE_BOUNCE: begin
                  if (!dir_q) begin
                     if (idx_q >= IDX_LAST) begin
                        dir_d = 1'b1;
                        idx_d = IDX_PEN;
                     end else begin
                        idx_d = idx_q + IDX_ONE;
                     end
                  end else begin
                     if (idx_q == '0) begin
                        dir_d = 1'b0;
                        idx_d = IDX_ONE;
                     end else begin
                        idx_d = idx_q - IDX_ONE;
                     end
                  end
               end
               default: idx_d = idx_q;
            endcase
         end
      end
   end

   always_comb begin
      pattern = '0;
      case (mode_q)
         MODE_UP, MODE_DOWN: pattern = idx_q;
         MODE_GRAY:          pattern = idx_q ^ (idx_q >> 1);
         MODE_BOUNCE:        pattern = IDX_ONE << idx_q;
         default:            pattern = '0;
      endcase
   end

`ifdef LED_SEQ_PWM_EN
   logic [3:0] pwm_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 4'd1;
      end
   end

   assign lit = pattern & {WIDTH{pwm_cnt_q < brightness}};
`else
   assign lit = pattern;
`endif

   always_comb begin
      if (ACTIVE_LOW != 0) begin
         led = ~lit;
      end else begin
         led = lit;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= 32'd1;
         idx_q   <= '0;
         dir_q   <= 1'b0;
         mode_q  <= MODE_UP;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         tick_q  <= strobe;
      end
   end

   assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (WAIT_TIME=4, WIDTH=4, ACTIVE_LOW=1).
module tb_led_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] mode;
   logic       pause;
   logic       step;
   logic [3:0] led;
   logic       tick;
`ifdef LED_SEQ_PWM_EN
   logic [3:0] brightness;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   led_sequencer #(
      .WAIT_TIME (4),
      .WIDTH     (4),
      .ACTIVE_LOW(1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .pause     (pause),
      .step      (step),
`ifdef LED_SEQ_PWM_EN
      .brightness(brightness),
`endif
      .led       (led),
      .tick      (tick)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_step();
      step = 1'b1;
      cyc();
      step = 1'b0;
   endtask

   // Active-low drive of a lit pattern.
   function automatic logic [3:0] drv(input logic [3:0] p);
      return ~p;
   endfunction

   initial begin
      logic [3:0]  v;
      logic [3:0]  prev;
      logic [3:0]  cur;
      int unsigned pos;
      int unsigned ticks;

      reset = 1'b1;
      mode  = 2'b00;
      pause = 1'b0;
      step  = 1'b0;
`ifdef LED_SEQ_PWM_EN
      brightness = 4'd4;
`endif
      cyc();
      cyc();
      check("rst_led", led, 4'hF);
      check("rst_tick", tick, 0);

      // Count up: strobe every 4th edge after reset release.
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         v = 4'(k / 4);
         check("up_led", led, drv(v));
         check("up_tick", tick, (k % 4 == 0) ? 1 : 0);
      end

      // Bounce via single steps; first step loads position 0.
      pause = 1'b1;
      mode  = 2'b11;
      for (int n = 0; n < 28; n++) begin
         pulse_step();
         pos = ((n % 6) <= 3) ? (n % 6) : (6 - (n % 6));
         v   = 4'(4'b0001 << pos);
         check("bounce_led", led, drv(v));
         check("bounce_tick", tick, 1);
      end

      // Gray: load, then 16 steps with single-bit changes, wrapping to 0.
      mode = 2'b10;
      pulse_step();
      check("gray_load", led, 4'hF);
      prev = 4'h0;
      for (int n = 1; n <= 16; n++) begin
         pulse_step();
         v = 4'(n);
         v = v ^ (v >> 1);
         check("gray_led", led, drv(v));
         cur = ~led;
         check("gray_hamming", $countones(cur ^ prev), 1);
         prev = cur;
      end

      // Up to idx 1 by steps, then free-run with a mid-interval switch to down.
      mode = 2'b00;
      pulse_step();
      check("up_load", led, 4'hF);
      pulse_step();
      check("up_step1", led, 4'hE);
      pause = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 1) mode = 2'b01;
         v = (k < 4) ? 4'h1 : ((k < 8) ? 4'hF : 4'hE);
         check("switch_led", led, drv(v));
         check("switch_tick", tick, (k == 4 || k == 8) ? 1 : 0);
      end

      // Step is ignored while running.
      step = 1'b1;
      cyc();
      step = 1'b0;
      check("step_ignored_led", led, drv(4'hE));
      check("step_ignored_tick", tick, 0);
      cyc();

      // Prescaler now at 3; pause, hold, then three manual steps.
      pause = 1'b1;
      ticks = 0;
      for (int k = 0; k < 50; k++) begin
         cyc();
         if (tick) ticks++;
      end
      check("pause_hold_led", led, drv(4'hE));
      for (int k = 0; k < 3; k++) begin
         step = 1'b1;
         cyc();
         step = 1'b0;
         if (tick) ticks++;
         cyc();
         if (tick) ticks++;
      end
      check("pause_ticks", ticks, 3);
      check("pause_steps_led", led, drv(4'hB));
      pause = 1'b0;
      cyc();
      check("resume_early_led", led, drv(4'hB));
      check("resume_early_tick", tick, 0);
      cyc();
      check("resume_strobe_led", led, drv(4'hA));
      check("resume_strobe_tick", tick, 1);

      // Reset lands on the edge where a strobe is due.
      cyc();
      cyc();
      cyc();
      check("pre_reset_led", led, drv(4'hA));
      reset = 1'b1;
      mode  = 2'b00;
      cyc();
      check("rst_strobe_led", led, 4'hF);
      check("rst_strobe_tick", tick, 0);
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         check("post_rst_led", led, (k < 4) ? 4'hF : 4'hE);
         check("post_rst_tick", tick, (k == 4) ? 1 : 0);
      end

`ifdef LED_SEQ_PWM_EN
      pause = 1'b1;
      ticks = 0;
      for (int k = 0; k < 16; k++) begin
         cyc();
         if (led[0] == 1'b0) ticks++;
      end
      check("pwm_duty", ticks, 4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
